mem_wb: RTL and testbench
=========================

Name: mem_wb

Overview:
- Pipeline register between the memory stage and write-back in the 5-stage MIPS32 core.
- Captures the memory stage's GPR write request, HI/LO write request and LL/SC link-bit update.
- Presents those to write-back, applying the global stall vector and exception flush.
- Owns the architectural HI/LO and LLbit state, with bypassed read ports for the execute and memory stages.

Parameters:
DATA_W, 32, GPR/HI/LO data width
ADDR_W, 5, GPR address width

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  reset; synchronous, active-high
stall  input  6  global stall vector, bit0=pc … bit4=mem, bit5=wb
flush  input  1  exception flush, highest priority after rst
mem_wd  input  ADDR_W  destination GPR from memory stage
mem_wreg  input  1  GPR write enable from memory stage
mem_wdata  input  DATA_W  GPR write data from memory stage
mem_whilo  input  1  HI/LO write enable from memory stage
mem_hi  input  DATA_W  HI write data
mem_lo  input  DATA_W  LO write data
mem_llbit_we  input  1  LLbit write enable (LL/SC)
mem_llbit_value  input  1  LLbit write value
wb_wd  output  ADDR_W  registered destination GPR to regfile
wb_wreg  output  1  registered GPR write enable
wb_wdata  output  DATA_W  registered GPR write data
wb_whilo  output  1  registered HI/LO write enable
wb_hi  output  DATA_W  registered HI data
wb_lo  output  DATA_W  registered LO data
wb_llbit_we  output  1  registered LLbit write enable
wb_llbit_value  output  1  registered LLbit value
hi_o  output  DATA_W  architectural HI, bypassed from wb stage
lo_o  output  DATA_W  architectural LO, bypassed from wb stage
llbit_o  output  1  architectural LLbit, bypassed from wb stage

Behaviour:
- rst=1 at clock edge: every wb_* output clears to 0. wb_wd resets to NOPRegAddr (0). HI=0, LO=0, LLbit=0.
- Register update priority per edge:
  - rst
  - flush: load bubble; all wb_* =0; LLbit register cleared to 0.
  - stall[4]=1, stall[5]=0: load bubble; mem stalled, wb proceeds, so no duplicate write-back.
  - stall[4]=1, stall[5]=1: hold all wb_* values.
  - stall[4]=0: capture all mem_* inputs.
- stall[4]=0 with stall[5]=1 is illegal. The control unit never generates it. Behave as capture.
- Latency: mem_* to wb_* is 1 cycle.
- HI/LO state (sub-module):
  - On edge, if wb_whilo=1 and not rst, HI<=wb_hi and LO<=wb_lo.
  - Write occurs the cycle after the wb_* capture.
- HI/LO read bypass (combinational):
  - wb_whilo=1: hi_o/lo_o = wb_hi/wb_lo.
  - Otherwise: hi_o/lo_o = HI/LO.
  - During rst: 0.
- LLbit state:
  - On edge, flush clears it, taking priority over any write.
  - Else, if wb_llbit_we=1, LLbit<=wb_llbit_value.
- llbit_o bypass:
  - flush=1: 0.
  - Else wb_llbit_we=1: wb_llbit_value.
  - Else: LLbit.
- Held state (stall[5]=1) with wb_whilo=1 rewrites the same HI/LO value each cycle. This is idempotent and acceptable.
- Bubble: wb_wreg=0, wb_whilo=0, wb_llbit_we=0, and data fields 0, so waveforms stay clean.
- Reset mid-stall or mid-flush: rst wins. The next non-reset edge follows the normal priority.

Decomposition:
- Shared defines package: RstEnable, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RegBus, RegAddrBus, stall bit indices (STALL_MEM=4, STALL_WB=5).
- One sub-module, hilo_reg: HI/LO storage plus write port. The bypass mux stays in mem_wb.

Test Plan:
- Reset: hold rst=1 for 2 cycles with mem_* non-zero. Require all wb_*=0, hi_o=lo_o=0, llbit_o=0.
- Capture: mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, stall=0. Next cycle require wb_wd=5, wb_wreg=1, wb_wdata=0xDEADBEEF.
- Stall:
  - stall=6'b011111, new mem_* presented: require bubble, wb_wreg=0.
  - stall=6'b111111: require the previous wb_* to be held unchanged for 3 cycles.
- HI/LO:
  - mem_whilo=1, hi=0x11, lo=0x22. The cycle it reaches wb requires hi_o=0x11 and lo_o=0x22 via bypass.
  - The next cycle, with wb_whilo=0, requires the same values from storage.
- LLbit:
  - mem_llbit_we=1, value=1: llbit_o=1 from the wb cycle onward.
  - Assert flush one cycle: llbit_o=0 immediately, and the stored LLbit=0 after the edge.
- Flush vs stall: flush=1 with stall=6'b111111 and valid mem_*. Require bubble, since flush beats hold.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared defines for the MEM/WB pipeline register: reset/enable encodings,
// bus types, stall vector bit positions and the per-edge update decision.
package mem_wb_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic RstDisable   = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

  localparam reg_bus_t      ZeroWord   = '0;
  localparam reg_addr_bus_t NOPRegAddr = '0;

  localparam int STALL_W   = 6;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  typedef enum logic [1:0] {
    WB_CAPTURE = 2'd0,
    WB_BUBBLE  = 2'd1,
    WB_HOLD    = 2'd2,
    WB_RESET   = 2'd3
  } wb_action_e;

  // mem stalled while wb proceeds must insert a bubble, otherwise the same
  // instruction would write back twice. stall[4]=0,stall[5]=1 never occurs
  // and simply falls through to capture.
  function automatic wb_action_e wb_action(input logic rst, input logic flush,
                                           input logic [STALL_W-1:0] stall);
    wb_action_e act;
    act = WB_CAPTURE;
    if (rst == RstEnable)                      act = WB_RESET;
    else if (flush)                            act = WB_BUBBLE;
    else if (stall[STALL_MEM] && !stall[STALL_WB]) act = WB_BUBBLE;
    else if (stall[STALL_MEM] &&  stall[STALL_WB]) act = WB_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/mem_wb_hilo_reg.sv
// Architectural HI/LO storage with a single write port driven from write-back.
module hilo_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_hi,
  input  logic [DATA_W-1:0] wr_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_en == WriteEnable) begin
      hi <= wr_hi;
      lo <= wr_lo;
    end
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register; also owns HI/LO and LLbit with write-back bypass
// so execute/memory see a value being retired this cycle.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   mem_wd,
  input  logic                mem_wreg,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_whilo,
  input  logic [DATA_W-1:0]   mem_hi,
  input  logic [DATA_W-1:0]   mem_lo,
  input  logic                mem_llbit_we,
  input  logic                mem_llbit_value,
  output logic [ADDR_W-1:0]   wb_wd,
  output logic                wb_wreg,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic                wb_whilo,
  output logic [DATA_W-1:0]   wb_hi,
  output logic [DATA_W-1:0]   wb_lo,
  output logic                wb_llbit_we,
  output logic                wb_llbit_value,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                llbit_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              llbit_we;
    logic              llbit_value;
  } wb_t;

  // Bubble clears data fields as well as enables so waveforms stay readable.
  localparam wb_t WB_BUBBLE_VAL = '{
    wd:          ADDR_W'(NOPRegAddr),
    wreg:        WriteDisable,
    wdata:       '0,
    whilo:       WriteDisable,
    hi:          '0,
    lo:          '0,
    llbit_we:    WriteDisable,
    llbit_value: 1'b0
  };

  wb_t        mem_req;
  wb_t        wb_q;
  wb_action_e act;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic       llbit_q;

  assign mem_req = '{
    wd:          mem_wd,
    wreg:        mem_wreg,
    wdata:       mem_wdata,
    whilo:       mem_whilo,
    hi:          mem_hi,
    lo:          mem_lo,
    llbit_we:    mem_llbit_we,
    llbit_value: mem_llbit_value
  };

  assign act = wb_action(rst, flush, stall);

  always_ff @(posedge clk) begin
    case (act)
      WB_RESET:   wb_q <= WB_BUBBLE_VAL;
      WB_BUBBLE:  wb_q <= WB_BUBBLE_VAL;
      WB_HOLD:    wb_q <= wb_q;
      default:    wb_q <= mem_req;
    endcase
  end

  assign wb_wd          = wb_q.wd;
  assign wb_wreg        = wb_q.wreg;
  assign wb_wdata       = wb_q.wdata;
  assign wb_whilo       = wb_q.whilo;
  assign wb_hi          = wb_q.hi;
  assign wb_lo          = wb_q.lo;
  assign wb_llbit_we    = wb_q.llbit_we;
  assign wb_llbit_value = wb_q.llbit_value;

  // A held wb_whilo rewrites the same HI/LO each stalled cycle; harmless.
  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wb_q.whilo),
    .wr_hi (wb_q.hi),
    .wr_lo (wb_q.lo),
    .hi    (hi_q),
    .lo    (lo_q)
  );

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst == RstEnable) begin
      hi_o = '0;
      lo_o = '0;
    end else if (wb_q.whilo == WriteEnable) begin
      hi_o = wb_q.hi;
      lo_o = wb_q.lo;
    end
  end

  // Flush breaks any LL/SC reservation and beats a pending write-back update.
  always_ff @(posedge clk) begin
    if (rst == RstEnable)                    llbit_q <= 1'b0;
    else if (flush)                          llbit_q <= 1'b0;
    else if (wb_q.llbit_we == WriteEnable)   llbit_q <= wb_q.llbit_value;
  end

  always_comb begin
    llbit_o = llbit_q;
    if (flush)                               llbit_o = 1'b0;
    else if (wb_q.llbit_we == WriteEnable)   llbit_o = wb_q.llbit_value;
  end

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: expected wb/bypass values are queued when each
// step is driven and checked half a cycle after the capturing edge.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        mem_llbit_we, mem_llbit_value;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi, wb_lo;
  logic        wb_llbit_we, wb_llbit_value;
  logic [31:0] hi_o, lo_o;
  logic        llbit_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llwe;
    logic        llv;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        llbit_o;
  } exp_t;

  exp_t exp_q[$];

  mem_wb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
    .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_mem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                         input logic llwe, input logic llv);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata; mem_whilo = whilo;
    mem_hi = hi; mem_lo = lo; mem_llbit_we = llwe; mem_llbit_value = llv;
  endtask

  function automatic exp_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                              input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                              input logic llwe, input logic llv, input logic [31:0] hio,
                              input logic [31:0] loo, input logic llo);
    exp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo; e.hi = hi; e.lo = lo;
    e.llwe = llwe; e.llv = llv; e.hi_o = hio; e.lo_o = loo; e.llbit_o = llo;
    return e;
  endfunction

  // One clock: queue the expectation, take the edge, compare on the falling edge.
  task automatic cycle(input string tag, input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x = exp_q.pop_front();
    chk({tag, ".wd"},       32'(wb_wd),          32'(x.wd));
    chk({tag, ".wreg"},     32'(wb_wreg),        32'(x.wreg));
    chk({tag, ".wdata"},    wb_wdata,            x.wdata);
    chk({tag, ".whilo"},    32'(wb_whilo),       32'(x.whilo));
    chk({tag, ".wb_hi"},    wb_hi,               x.hi);
    chk({tag, ".wb_lo"},    wb_lo,               x.lo);
    chk({tag, ".llwe"},     32'(wb_llbit_we),    32'(x.llwe));
    chk({tag, ".llv"},      32'(wb_llbit_value), 32'(x.llv));
    chk({tag, ".hi_o"},     hi_o,                x.hi_o);
    chk({tag, ".lo_o"},     lo_o,                x.lo_o);
    chk({tag, ".llbit_o"},  32'(llbit_o),        32'(x.llbit_o));
  endtask

  exp_t z;

  initial begin
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    set_mem(5'd7, 1, 32'hAAAA5555, 1, 32'h5, 32'h6, 1, 1);

    // Reset with busy mem inputs
    cycle("rst1", mk(0,0,0,0,0,0,0,0, 0,0,0));
    cycle("rst2", mk(0,0,0,0,0,0,0,0, 0,0,0));

    rst = 1'b0;
    set_mem(5'd5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle("cap", mk(5,1,32'hDEADBEEF,0,0,0,0,0, 0,0,0));

    stall = 6'b011111;
    set_mem(5'd9, 1, 32'h12345678, 0, 0, 0, 0, 0);
    cycle("bubble", mk(0,0,0,0,0,0,0,0, 0,0,0));

    stall = 6'b000000;
    set_mem(5'd3, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    cycle("cap2", mk(3,1,32'hCAFEF00D,0,0,0,0,0, 0,0,0));

    stall = 6'b111111;
    set_mem(5'd10, 1, 32'h55, 1, 32'h1, 32'h2, 1, 1);
    for (int i = 0; i < 3; i++)
      cycle($sformatf("hold%0d", i), mk(3,1,32'hCAFEF00D,0,0,0,0,0, 0,0,0));

    stall = 6'b100000;
    set_mem(5'd1, 1, 32'hABCD, 0, 0, 0, 0, 0);
    cycle("illegal_cap", mk(1,1,32'hABCD,0,0,0,0,0, 0,0,0));

    // HI/LO bypass then storage
    stall = 6'b000000;
    set_mem(5'd0, 0, 0, 1, 32'h11, 32'h22, 0, 0);
    cycle("hilo_byp", mk(0,0,0,1,32'h11,32'h22,0,0, 32'h11,32'h22,0));
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("hilo_reg", mk(0,0,0,0,0,0,0,0, 32'h11,32'h22,0));

    // LLbit bypass then storage
    set_mem(0, 0, 0, 0, 0, 0, 1, 1);
    cycle("ll_byp", mk(0,0,0,0,0,0,1,1, 32'h11,32'h22,1));
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("ll_reg", mk(0,0,0,0,0,0,0,0, 32'h11,32'h22,1));

    flush = 1'b1;
    #1 chk("flush_now.llbit_o", 32'(llbit_o), 32'd0);
    cycle("flush", mk(0,0,0,0,0,0,0,0, 32'h11,32'h22,0));
    flush = 1'b0;
    #1 chk("flush_after.llbit_o", 32'(llbit_o), 32'd0);

    // Flush beats hold, and beats a pending LLbit write
    @(negedge clk);
    set_mem(5'd4, 1, 32'h77, 1, 32'h33, 32'h44, 1, 1);
    cycle("fs_cap", mk(4,1,32'h77,1,32'h33,32'h44,1,1, 32'h33,32'h44,1));
    flush = 1'b1; stall = 6'b111111;
    set_mem(5'd8, 1, 32'h99, 1, 32'h88, 32'h88, 1, 1);
    cycle("fs_flush", mk(0,0,0,0,0,0,0,0, 32'h33,32'h44,0));
    flush = 1'b0; stall = 6'b000000;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fs_after.llbit_o", 32'(llbit_o), 32'd0);
    chk("fs_after.hi_o", hi_o, 32'h33);

    // Reset during a held stall clears HI/LO even with wb_whilo pending
    @(negedge clk);
    set_mem(5'd2, 1, 32'h10, 1, 32'h66, 32'h77, 0, 0);
    cycle("rs_cap", mk(2,1,32'h10,1,32'h66,32'h77,0,0, 32'h66,32'h77,0));
    rst = 1'b1; stall = 6'b111111;
    cycle("rs_rst", mk(0,0,0,0,0,0,0,0, 0,0,0));
    rst = 1'b0; stall = 6'b000000;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rs_post", mk(0,0,0,0,0,0,0,0, 0,0,0));

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
